// File: rtl/pc_sequencer.sv
// csRISC fetch-stage program-counter sequencer.
// Owns the architectural PC, issues fetch requests and buffers redirects.
module pc_sequencer #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_valid,
  input  logic [1:0]        branch_control_in,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              stall,
  input  logic              halt,
  input  logic              fetch_ready,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              flush,
  output logic              halted,
  output logic              illegal_branch,
  output logic [31:0]       fetch_count
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  logic [1:0]        state;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_target;

  logic              live_valid;
  logic              live_illegal;
  logic [ADDR_W-1:0] live_target;

  logic              redir_valid;
  logic [ADDR_W-1:0] redir_target;
  logic              accept;
  logic              outstanding;
  logic              can_issue;

  always_comb begin
    live_valid   = 1'b0;
    live_illegal = 1'b0;
    live_target  = '0;
    unique case (1'b1)
      branch_valid && (branch_control_in == 2'b01): begin
        live_valid  = 1'b1;
        live_target = ex_pc + branch_offset;
      end
      branch_valid && (branch_control_in == 2'b10): begin
        live_valid  = 1'b1;
        live_target = reg_target;
      end
      branch_valid && (branch_control_in == 2'b11): begin
        live_illegal = 1'b1;
      end
      default: ;
    endcase
  end

  // A live redirect outranks the buffered one.
  assign redir_valid  = live_valid | pend_valid;
  assign redir_target = live_valid ? live_target : pend_target;

  assign accept      = fetch_valid & fetch_ready;
  assign outstanding = fetch_valid & ~fetch_ready;
  assign can_issue   = ~outstanding & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_BOOT;
      pc_out         <= RESET_PC;
      fetch_valid    <= 1'b0;
      flush          <= 1'b0;
      halted         <= 1'b0;
      illegal_branch <= 1'b0;
      fetch_count    <= '0;
      pend_valid     <= 1'b0;
      pend_target    <= '0;
    end else begin
      flush <= 1'b0;
      unique case (state)
        S_BOOT: begin
          state       <= S_RUN;
          fetch_valid <= 1'b1;
          pc_out      <= RESET_PC;
        end
        S_RUN: begin
          if (accept) begin
            fetch_count <= fetch_count + 32'd1;
          end
          if (live_illegal) begin
            illegal_branch <= 1'b1;
          end
          if (halt) begin
            state       <= S_HALT;
            halted      <= 1'b1;
            fetch_valid <= 1'b0;
            pend_valid  <= 1'b0;
            flush       <= redir_valid;
          end else if (can_issue) begin
            fetch_valid <= 1'b1;
            pend_valid  <= 1'b0;
            if (redir_valid) begin
              pc_out <= redir_target;
              flush  <= 1'b1;
            end else begin
              pc_out <= pc_out + STEP;
            end
          end else begin
            // Held request or stall: park any new redirect.
            if (!outstanding) begin
              fetch_valid <= 1'b0;
            end
            if (live_valid) begin
              pend_valid  <= 1'b1;
              pend_target <= live_target;
            end
          end
        end
        S_HALT: ;
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer.
// Directed scenarios plus random traffic against a queue-based model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_valid;
  logic [1:0]  branch_control_in;
  logic [31:0] ex_pc;
  logic [31:0] branch_offset;
  logic [31:0] reg_target;
  logic        stall;
  logic        halt;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc_out;
  logic        flush;
  logic        halted;
  logic        illegal_branch;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W  (32),
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .branch_valid     (branch_valid),
    .branch_control_in(branch_control_in),
    .ex_pc            (ex_pc),
    .branch_offset    (branch_offset),
    .reg_target       (reg_target),
    .stall            (stall),
    .halt             (halt),
    .fetch_ready      (fetch_ready),
    .fetch_valid      (fetch_valid),
    .pc_out           (pc_out),
    .flush            (flush),
    .halted           (halted),
    .illegal_branch   (illegal_branch),
    .fetch_count      (fetch_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Model: mode 0 = boot, 1 = run, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_v;
  logic        m_flush;
  logic        m_halted;
  logic        m_ill;
  logic [31:0] m_cnt;
  logic [31:0] m_pend[$];

  task automatic model_update();
    logic        live;
    logic [31:0] tgt;
    logic        held;
    if (rst) begin
      m_mode = 0; m_pc = 32'h0; m_v = 1'b0; m_flush = 1'b0;
      m_halted = 1'b0; m_ill = 1'b0; m_cnt = 32'h0;
      m_pend.delete();
      return;
    end
    m_flush = 1'b0;
    if (m_mode == 0) begin
      m_mode = 1; m_v = 1'b1; m_pc = 32'h0;
    end else if (m_mode == 1) begin
      live = branch_valid &&
             (branch_control_in == 2'd1 || branch_control_in == 2'd2);
      tgt  = (branch_control_in == 2'd1) ? ex_pc + branch_offset
                                         : reg_target;
      held = m_v && !fetch_ready;
      if (m_v && fetch_ready) m_cnt = m_cnt + 1;
      if (branch_valid && branch_control_in == 2'd3) m_ill = 1'b1;
      if (halt) begin
        m_flush = live || (m_pend.size() != 0);
        m_pend.delete();
        m_mode = 2; m_v = 1'b0; m_halted = 1'b1;
      end else begin
        if (live) begin
          m_pend.delete();
          m_pend.push_back(tgt);
        end
        if (!held && !stall) begin
          m_v = 1'b1;
          if (m_pend.size() != 0) begin
            m_pc = m_pend.pop_front();
            m_flush = 1'b1;
          end else begin
            m_pc = m_pc + 32'd4;
          end
        end else if (!held) begin
          m_v = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("pc_out", pc_out, m_pc);
    check("fetch_valid", 32'(fetch_valid), 32'(m_v));
    check("flush", 32'(flush), 32'(m_flush));
    check("halted", 32'(halted), 32'(m_halted));
    check("illegal_branch", 32'(illegal_branch), 32'(m_ill));
    check("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic idle_inputs();
    branch_valid = 1'b0; branch_control_in = 2'd0;
    ex_pc = '0; branch_offset = '0; reg_target = '0;
    stall = 1'b0; halt = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fetch_ready = 1'b1;
    idle_inputs();
    step();
    step();
    check("rst_pc", pc_out, 32'h0);
    check("rst_valid", 32'(fetch_valid), 32'd0);

    // Boot then sequential fetches.
    rst = 1'b0;
    step();
    check("boot_pc", pc_out, 32'h0);
    check("boot_valid", 32'(fetch_valid), 32'd1);
    step(); check("seq_4", pc_out, 32'h4);
    step(); check("seq_8", pc_out, 32'h8);
    step(); check("seq_c", pc_out, 32'hC);
    step(); check("count_4", fetch_count, 32'd4);

    // PC-relative redirect with negative offset.
    branch_valid = 1'b1; branch_control_in = 2'd1;
    ex_pc = 32'h100; branch_offset = 32'hFFFF_FFF8;
    step();
    check("rel_pc", pc_out, 32'hF8);
    check("rel_flush", 32'(flush), 32'd1);
    idle_inputs();
    step();
    check("rel_next", pc_out, 32'hFC);
    check("rel_flush_off", 32'(flush), 32'd0);

    // Redirect arriving while a request is held.
    branch_valid = 1'b1; branch_control_in = 2'd2; reg_target = 32'h20;
    step();
    idle_inputs();
    fetch_ready = 1'b0;
    step();
    branch_valid = 1'b1; branch_control_in = 2'd2; reg_target = 32'h400;
    step();
    check("hold_pc", pc_out, 32'h20);
    idle_inputs();
    step();
    check("hold_pc2", pc_out, 32'h20);
    check("hold_noflush", 32'(flush), 32'd0);
    fetch_ready = 1'b1;
    step();
    check("held_redir_pc", pc_out, 32'h400);
    check("held_redir_flush", 32'(flush), 32'd1);

    // Stall with two redirects: newest wins.
    stall = 1'b1;
    step();
    branch_valid = 1'b1; branch_control_in = 2'd2; reg_target = 32'h80;
    step();
    reg_target = 32'h90;
    step();
    check("stall_valid", 32'(fetch_valid), 32'd0);
    idle_inputs();
    step();
    check("stall_redir_pc", pc_out, 32'h90);
    check("stall_redir_flush", 32'(flush), 32'd1);
    step();
    check("stall_next", pc_out, 32'h94);

    // Reserved code: no redirect, sticky flag.
    branch_valid = 1'b1; branch_control_in = 2'd3; reg_target = 32'h500;
    step();
    check("ill_pc", pc_out, 32'h98);
    check("ill_flag", 32'(illegal_branch), 32'd1);
    idle_inputs();
    step();
    check("ill_sticky", 32'(illegal_branch), 32'd1);

    // Halt beats a same-cycle redirect; reset mid-halt.
    halt = 1'b1; branch_valid = 1'b1; branch_control_in = 2'd1;
    ex_pc = 32'h200; branch_offset = 32'h10;
    step();
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_valid", 32'(fetch_valid), 32'd0);
    idle_inputs();
    step();
    step();
    check("halt_hold_pc", pc_out, 32'h9C);
    rst = 1'b1;
    step();
    check("halt_rst_flags", {29'd0, halted, illegal_branch, flush}, 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_pc", pc_out, 32'h0);
    check("post_rst_valid", 32'(fetch_valid), 32'd1);

    // Random traffic including wrap-around targets.
    for (int i = 0; i < 3000; i++) begin
      rst               = ($urandom_range(99) < 3);
      branch_valid      = ($urandom_range(99) < 30);
      branch_control_in = 2'($urandom_range(3));
      ex_pc             = $urandom;
      branch_offset     = ($urandom_range(1) == 1) ? $urandom
                                                   : 32'($urandom_range(64)) - 32'd32;
      reg_target        = $urandom;
      stall             = ($urandom_range(99) < 20);
      halt              = ($urandom_range(99) < 1);
      fetch_ready       = ($urandom_range(99) < 70);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
